// File: rtl/sci_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sci_alu_pkg
// Description : Shared widths, opcode type, reserved-opcode boundary and the
//               scheduler state encoding for the scientific ALU scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package sci_alu_pkg;

  localparam int SCI_ALU_DW  = 64;
  localparam int SCI_ALU_OPW = 4;

  typedef logic [SCI_ALU_OPW-1:0] sci_alu_opcode_t;

  // Opcodes at or above this value are reserved when opcode checking is built in
  localparam sci_alu_opcode_t SCI_ALU_OP_RSVD_FIRST = 4'hC;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_EXEC = 2'd1,
    SCHED_RESP = 2'd2
  } sci_alu_sched_state_t;

  function automatic logic sci_alu_op_reserved(input sci_alu_opcode_t op);
    return (op >= SCI_ALU_OP_RSVD_FIRST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sci_alu_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : sci_alu_scheduler_if
// Description : Requester fabric and ALU-side signal bundle of the scheduler.
//               slave  = scheduler view, master = fabric / ALU view.
// Revision    : 1.0 - initial release
// ============================================================================
interface sci_alu_scheduler_if #(
  parameter int NREQ = 4
);
  import sci_alu_pkg::*;

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ*SCI_ALU_DW-1:0]  req_a;
  logic [NREQ*SCI_ALU_DW-1:0]  req_b;
  logic [NREQ*SCI_ALU_OPW-1:0] req_opcode;

  logic [NREQ-1:0]             rsp_valid;
  logic [NREQ-1:0]             rsp_ready;
  logic [SCI_ALU_DW-1:0]       rsp_result;
  logic                        rsp_exception;
  logic                        rsp_error;

  logic                        alu_enable;
  logic [SCI_ALU_DW-1:0]       alu_a_in;
  logic [SCI_ALU_DW-1:0]       alu_b_in;
  sci_alu_opcode_t             alu_opcode;
  logic [SCI_ALU_DW-1:0]       alu_result_out;
  logic                        alu_exception;
  logic                        alu_error;

  modport slave (
    input  req_valid, req_a, req_b, req_opcode, rsp_ready,
           alu_result_out, alu_exception, alu_error,
    output req_ready, rsp_valid, rsp_result, rsp_exception, rsp_error,
           alu_enable, alu_a_in, alu_b_in, alu_opcode
  );

  modport master (
    output req_valid, req_a, req_b, req_opcode, rsp_ready,
           alu_result_out, alu_exception, alu_error,
    input  req_ready, rsp_valid, rsp_result, rsp_exception, rsp_error,
           alu_enable, alu_a_in, alu_b_in, alu_opcode
  );

endinterface
`default_nettype wire

// File: rtl/sci_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sci_alu_rr_arbiter
// Description : Combinational NREQ-way round-robin pick. Grants the first
//               set request at or after ptr, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
module sci_alu_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  wire logic [NREQ-1:0] req,
  input  wire logic [IDXW-1:0] ptr,
  output logic      [NREQ-1:0] grant,
  output logic      [IDXW-1:0] grant_idx,
  output logic                 grant_any
);

  logic [IDXW-1:0] w_k;

  // Scan from the pointer upward; the first hit wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_k       = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_k = IDXW'((int'(ptr) + i) % NREQ);
      if (!grant_any && req[w_k]) begin
        grant[w_k] = 1'b1;
        grant_idx  = w_k;
        grant_any  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sci_alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sci_alu_scheduler
// Description : Round-robin sharing of one latched scientific ALU between
//               NREQ requesters. Operands are registered at grant, held on the
//               ALU for LATENCY enabled cycles, and the captured result/flags
//               are returned to the owning requester.
//               Optional build macro SCI_ALU_SCHED_OPCHK_EN: opcodes 4'hC..4'hF
//               bypass the ALU and answer immediately with rsp_error set.
// Revision    : 1.0 - initial release
// ============================================================================
module sci_alu_scheduler
  import sci_alu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  sci_alu_scheduler_if.slave  bus
);

  localparam int c_pw = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_cw = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(LATENCY - 1);

  sci_alu_sched_state_t   r_state;
  logic [c_pw-1:0]        r_rr_ptr;
  logic [c_pw-1:0]        r_owner;
  logic [c_cw-1:0]        r_cnt;
  logic [SCI_ALU_DW-1:0]  r_a;
  logic [SCI_ALU_DW-1:0]  r_b;
  sci_alu_opcode_t        r_op;
  logic                   r_alu_enable;
  logic [NREQ-1:0]        r_rsp_valid;
  logic [SCI_ALU_DW-1:0]  r_rsp_result;
  logic                   r_rsp_exception;
  logic                   r_rsp_error;

  logic [NREQ-1:0]        w_grant;
  logic [c_pw-1:0]        w_grant_idx;
  logic                   w_grant_any;
  logic                   w_accept;
  logic [SCI_ALU_DW-1:0]  w_sel_a;
  logic [SCI_ALU_DW-1:0]  w_sel_b;
  sci_alu_opcode_t        w_sel_op;
  logic                   w_sel_rsvd;
  logic [c_pw-1:0]        w_ptr_next;
  logic [NREQ-1:0]        w_owner_oh;

  sci_alu_rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (c_pw)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  // Grant is only offered while idle; rst masks it so reset values hold at once
  assign bus.req_ready = (r_state == SCHED_IDLE && !rst && w_grant_any) ? w_grant : '0;
  assign w_accept      = |(bus.req_valid & bus.req_ready);

  assign w_sel_a  = bus.req_a[int'(w_grant_idx) * SCI_ALU_DW +: SCI_ALU_DW];
  assign w_sel_b  = bus.req_b[int'(w_grant_idx) * SCI_ALU_DW +: SCI_ALU_DW];
  assign w_sel_op = bus.req_opcode[int'(w_grant_idx) * SCI_ALU_OPW +: SCI_ALU_OPW];

`ifdef SCI_ALU_SCHED_OPCHK_EN
  assign w_sel_rsvd = sci_alu_op_reserved(w_sel_op);
`else
  assign w_sel_rsvd = 1'b0;
`endif

  assign w_ptr_next = (w_grant_idx == c_pw'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
  assign w_owner_oh = NREQ'(1) << r_owner;

  // ALU operands only ever come from the registers, never straight from req_*
  assign bus.alu_enable    = r_alu_enable;
  assign bus.alu_a_in      = r_a;
  assign bus.alu_b_in      = r_b;
  assign bus.alu_opcode    = r_op;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_result    = r_rsp_result;
  assign bus.rsp_exception = r_rsp_exception;
  assign bus.rsp_error     = r_rsp_error;

  // Scheduler FSM: grant/capture in IDLE, hold ALU in EXEC, return result in RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= SCHED_IDLE;
      r_rr_ptr        <= '0;
      r_owner         <= '0;
      r_cnt           <= '0;
      r_a             <= '0;
      r_b             <= '0;
      r_op            <= '0;
      r_alu_enable    <= 1'b0;
      r_rsp_valid     <= '0;
      r_rsp_result    <= '0;
      r_rsp_exception <= 1'b0;
      r_rsp_error     <= 1'b0;
    end else begin
      case (r_state)
        SCHED_IDLE: begin
          if (w_accept) begin
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_op     <= w_sel_op;
            r_owner  <= w_grant_idx;
            r_rr_ptr <= w_ptr_next;
            r_cnt    <= '0;
            if (w_sel_rsvd) begin
              // Reserved opcode: answer without touching the ALU
              r_rsp_result    <= '0;
              r_rsp_error     <= 1'b1;
              r_rsp_exception <= 1'b0;
              r_rsp_valid     <= w_grant;
              r_state         <= SCHED_RESP;
            end else begin
              r_alu_enable <= 1'b1;
              r_state      <= SCHED_EXEC;
            end
          end
        end
        SCHED_EXEC: begin
          if (r_cnt == c_cnt_last) begin
            r_rsp_result    <= bus.alu_result_out;
            r_rsp_exception <= bus.alu_exception;
            r_rsp_error     <= bus.alu_error;
            r_alu_enable    <= 1'b0;
            r_rsp_valid     <= w_owner_oh;
            r_state         <= SCHED_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SCHED_RESP: begin
          if (bus.rsp_ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_state     <= SCHED_IDLE;
          end
        end
        default: begin
          r_state <= SCHED_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sci_alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sci_alu_scheduler
// Description : Self-checking bench for sci_alu_scheduler with a stub ALU,
//               random requesters and a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sci_alu_scheduler;
  import sci_alu_pkg::*;

  localparam int NREQ    = 4;
  localparam int LATENCY = 2;

  typedef struct {
    int          owner;
    logic [63:0] res;
    logic        exc;
    logic        err;
    int          rise;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sci_alu_scheduler_if #(.NREQ(NREQ)) bus ();

  sci_alu_scheduler #(
    .NREQ    (NREQ),
    .LATENCY (LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- stub ALU and reference rules ----------------
  function automatic logic [63:0] stub_res(input logic [63:0] a, input logic [63:0] b,
                                           input logic [3:0] op);
    case (op)
      4'h0:    return $realtobits($bitstoreal(a) + $bitstoreal(b));
      4'h1:    return $realtobits($bitstoreal(a) * $bitstoreal(b));
      default: return a ^ {b[31:0], b[63:32]} ^ {60'd0, op};
    endcase
  endfunction
  function automatic logic stub_exc(input logic [3:0] op);
    return (op == 4'h5) || (op == 4'h6);
  endfunction
  function automatic logic stub_err(input logic [3:0] op);
    return (op == 4'h5) || (op == 4'h7);
  endfunction
  function automatic bit op_rsvd(input logic [3:0] op);
`ifdef SCI_ALU_SCHED_OPCHK_EN
    return op >= 4'hC;
`else
    return 1'b0;
`endif
  endfunction
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction
  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction
  function automatic logic [63:0] rnd64();
    if ($urandom_range(0, 1) == 0)
      return $realtobits(real'($urandom_range(0, 4000)) / 16.0 - 100.0);
    return {$urandom, $urandom};
  endfunction

  assign bus.alu_result_out = stub_res(bus.alu_a_in, bus.alu_b_in, bus.alu_opcode);
  assign bus.alu_exception  = stub_exc(bus.alu_opcode);
  assign bus.alu_error      = stub_err(bus.alu_opcode);

  // ---------------- shared bench state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t sb[$];
  int grant_log[$];
  int n_iss  = 0;
  int n_done = 0;
  int mptr   = 0;
  int en_lo  = 1;
  int en_hi  = 0;
  logic [63:0] cur_a, cur_b;
  logic [3:0]  cur_op;
  int acc_cnt  [NREQ];
  int acc_seen [NREQ];
  int go_cnt   [NREQ];
  int go_seen  [NREQ];
  logic [63:0] go_a [NREQ];
  logic [63:0] go_b [NREQ];
  logic [3:0]  go_op[NREQ];
  int mode = 0;
  logic [NREQ-1:0] rdy_dir = '1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- requester / response-ready driver ----------------
  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_opcode = '0;
    bus.rsp_ready  = '1;
    for (int i = 0; i < NREQ; i++) begin
      acc_seen[i] = 0;
      go_seen[i]  = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_seen[i] != acc_cnt[i]) begin
          acc_seen[i]      = acc_cnt[i];
          bus.req_valid[i] = 1'b0;
        end
        if (rst && mode == 0) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i]) begin
          if (go_seen[i] != go_cnt[i]) begin
            go_seen[i] = go_cnt[i];
            bus.req_a[i*64 +: 64]     = go_a[i];
            bus.req_b[i*64 +: 64]     = go_b[i];
            bus.req_opcode[i*4 +: 4]  = go_op[i];
            bus.req_valid[i]          = 1'b1;
          end else if (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0)) begin
            bus.req_a[i*64 +: 64]     = rnd64();
            bus.req_b[i*64 +: 64]     = rnd64();
            bus.req_opcode[i*4 +: 4]  = 4'($urandom_range(0, 15));
            bus.req_valid[i]          = 1'b1;
          end
        end
      end
      for (int i = 0; i < NREQ; i++)
        bus.rsp_ready[i] = (mode == 1) ? ($urandom_range(0, 3) != 0) : rdy_dir[i];
    end
  end

  // ---------------- grant watcher: model arbitration, push expectations ----------------
  int w_pick;
  exp_t e_new;
  logic [63:0] pa, pb;
  logic [3:0]  pop;
  always @(negedge clk) begin
    if (rst) begin
      mptr  = 0;
      en_lo = 1;
      en_hi = 0;
      n_iss <= 0;
    end else if (n_iss != n_done) begin
      chk("busy_no_ready", bus.req_ready, '0);
    end else begin
      w_pick = rr_pick(bus.req_valid, mptr);
      chk("grant", bus.req_ready, onehot(w_pick));
      if (w_pick >= 0 && bus.req_ready == onehot(w_pick)) begin
        pa  = bus.req_a[w_pick*64 +: 64];
        pb  = bus.req_b[w_pick*64 +: 64];
        pop = bus.req_opcode[w_pick*4 +: 4];
        e_new.owner = w_pick;
        if (op_rsvd(pop)) begin
          e_new.res  = '0;
          e_new.exc  = 1'b0;
          e_new.err  = 1'b1;
          e_new.rise = cyc + 1;
          en_lo      = cyc + 1;
          en_hi      = cyc;
        end else begin
          e_new.res  = stub_res(pa, pb, pop);
          e_new.exc  = stub_exc(pop);
          e_new.err  = stub_err(pop);
          e_new.rise = cyc + LATENCY + 1;
          en_lo      = cyc + 1;
          en_hi      = cyc + LATENCY;
        end
        cur_a  = pa;
        cur_b  = pb;
        cur_op = pop;
        sb.push_back(e_new);
        grant_log.push_back(w_pick);
        acc_cnt[w_pick]++;
        mptr = (w_pick + 1) % NREQ;
        n_iss <= n_iss + 1;
      end
    end
  end

  // ---------------- response monitor: pop and compare ----------------
  exp_t e_head;
  logic [NREQ-1:0] prev_v = '0;
  logic [63:0]     prev_res = '0;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      n_done <= 0;
      prev_v = '0;
    end else begin
      if (bus.rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", bus.rsp_valid, '0);
        end else begin
          e_head = sb[0];
          if (prev_v == '0) begin
            chk("rsp_owner",     bus.rsp_valid, onehot(e_head.owner));
            chk("rsp_result",    bus.rsp_result, e_head.res);
            chk("rsp_exception", bus.rsp_exception, e_head.exc);
            chk("rsp_error",     bus.rsp_error, e_head.err);
            chk("rsp_latency",   cyc, e_head.rise);
          end else begin
            chk("rsp_hold_valid",  bus.rsp_valid, prev_v);
            chk("rsp_hold_result", bus.rsp_result, prev_res);
          end
          if (bus.rsp_ready[e_head.owner]) begin
            void'(sb.pop_front());
            n_done <= n_done + 1;
          end
        end
      end
      prev_v   = bus.rsp_valid;
      prev_res = bus.rsp_result;
    end
  end

  // ---------------- ALU-side monitor: enable window and operand hold ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("alu_enable", bus.alu_enable, (cyc >= en_lo && cyc <= en_hi));
      if (bus.alu_enable) begin
        chk("alu_a_in",   bus.alu_a_in, cur_a);
        chk("alu_b_in",   bus.alu_b_in, cur_b);
        chk("alu_opcode", bus.alu_opcode, cur_op);
      end
    end
  end

  // ---------------- directed sequence helpers ----------------
  task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    go_a[i]  = a;
    go_b[i]  = b;
    go_op[i] = op;
    go_cnt[i]++;
  endtask

  task automatic wait_rsp(input int i, output int n_en);
    int k;
    n_en = 0;
    k    = 0;
    while (k < 60 && !bus.rsp_valid[i]) begin
      @(negedge clk);
      if (bus.alu_enable) n_en++;
      k++;
    end
    chk("rsp_wait", bus.rsp_valid[i], 1'b1);
  endtask

  task automatic wait_grants(input int n);
    int k;
    k = 0;
    while (k < 200 && grant_log.size() < n) begin
      @(negedge clk);
      k++;
    end
    chk("grant_wait", grant_log.size() >= n, 1'b1);
  endtask

  task automatic drain();
    int k;
    bit pend;
    k = 0;
    forever begin
      pend = 1'b0;
      for (int i = 0; i < NREQ; i++) if (go_cnt[i] != go_seen[i]) pend = 1'b1;
      if (k >= 1000 || (n_iss == n_done && bus.req_valid == '0 && !pend && bus.rsp_valid == '0))
        break;
      @(negedge clk);
      k++;
    end
    chk("drain", k < 1000, 1'b1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready",     bus.req_ready, '0);
    chk("rst_rsp_valid",     bus.rsp_valid, '0);
    chk("rst_rsp_result",    bus.rsp_result, '0);
    chk("rst_rsp_exception", bus.rsp_exception, '0);
    chk("rst_rsp_error",     bus.rsp_error, '0);
    chk("rst_alu_enable",    bus.alu_enable, '0);
    chk("rst_alu_a_in",      bus.alu_a_in, '0);
    chk("rst_alu_b_in",      bus.alu_b_in, '0);
    chk("rst_alu_opcode",    bus.alu_opcode, '0);
  endtask

  // ---------------- main sequence ----------------
  int base;
  int n_en;
  int order_exp [5];
  initial begin
    order_exp[0] = 0; order_exp[1] = 1; order_exp[2] = 2; order_exp[3] = 3; order_exp[4] = 0;
    for (int i = 0; i < NREQ; i++) begin
      acc_cnt[i] = 0;
      go_cnt[i]  = 0;
    end

    // Reset state with every requester already valid, then contention
    mode    = 2;
    rdy_dir = '1;
    repeat (3) @(posedge clk);
    #3;
    chk_reset_outputs();
    base = grant_log.size();
    rst  = 1'b0;
    wait_grants(base + 5);
    mode = 0;
    for (int k = 0; k < 5; k++)
      if (grant_log.size() > base + k) chk("contention_order", grant_log[base + k], order_exp[k]);
    drain();

    // Single request: 1.5 + 2.0 on requester 1
    issue(1, 64'h3FF8000000000000, 64'h4000000000000000, 4'h0);
    wait_rsp(1, n_en);
    chk("single_result", bus.rsp_result, 64'h400C000000000000);
    chk("single_enable_cycles", n_en, LATENCY);
    drain();

    // Response backpressure: rsp_ready low for 5 cycles
    rdy_dir = '0;
    issue(2, rnd64(), rnd64(), 4'h1);
    issue(3, rnd64(), rnd64(), 4'h2);
    begin
      int k;
      k = 0;
      while (k < 60 && bus.rsp_valid == '0) begin
        @(negedge clk);
        k++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_held", bus.rsp_valid != '0, 1'b1);
      chk("bp_no_ready",   bus.req_ready, '0);
    end
    rdy_dir = '1;
    drain();

    // Flag passthrough on requester 3
    issue(3, rnd64(), rnd64(), 4'h5);
    wait_rsp(3, n_en);
    chk("flag_error",     bus.rsp_error, 1'b1);
    chk("flag_exception", bus.rsp_exception, 1'b1);
    drain();

    // Opcode 4'hE: reserved with the checker built in, forwarded otherwise
    issue(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 4'hE);
    wait_rsp(0, n_en);
`ifdef SCI_ALU_SCHED_OPCHK_EN
    chk("rsvd_error",     bus.rsp_error, 1'b1);
    chk("rsvd_exception", bus.rsp_exception, 1'b0);
    chk("rsvd_result",    bus.rsp_result, '0);
    chk("rsvd_no_enable", n_en, 0);
`else
    chk("op_e_result",    bus.rsp_result,
        stub_res(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 4'hE));
    chk("op_e_enable",    n_en, LATENCY);
`endif
    drain();

    // Random traffic with random response backpressure
    mode = 1;
    repeat (1500) @(posedge clk);
    mode    = 0;
    rdy_dir = '1;
    drain();

    // Reset in the middle of EXEC
    issue(2, rnd64(), rnd64(), 4'h0);
    begin
      int k;
      k = 0;
      while (k < 60 && !bus.alu_enable) begin
        @(negedge clk);
        k++;
      end
    end
    chk("mid_exec_reached", bus.alu_enable, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    mode = 2;
    @(posedge clk);
    #3;
    base = grant_log.size();
    rst  = 1'b0;
    wait_grants(base + 1);
    mode = 0;
    if (grant_log.size() > base) chk("post_reset_grant", grant_log[base], 0);
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sci_alu_scheduler.md
# sci_alu_scheduler

Shares one latched scientific ALU between `NREQ` requesters. Each requester submits 64-bit real-encoded operands (IEEE-754 bit patterns, as produced by `$realtobits`) and a 4-bit opcode over a valid/ready handshake. The scheduler arbitrates round-robin, holds the ALU operands stable while `enable` is asserted for a fixed number of cycles, captures the result and flags, and returns them to the owning requester. It sits between the requester fabric and the `scientific_alu` shell.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; legal range 2..8.
- `LATENCY`, 2: number of cycles `alu_enable` is held before the result is sampled; minimum 1.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  reset, **asynchronous, active-high**.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_a`, `req_b`  in  NREQ*64  packed operands; requester i owns bits [64i+63:64i].
- `req_opcode`  in  NREQ*4  packed opcodes.
- `rsp_valid`  out  NREQ  per-requester response valid; one-hot or zero.
- `rsp_ready`  in  NREQ  per-requester response accept.
- `rsp_result`  out  64  shared result bus, valid where `rsp_valid` is set.
- `rsp_exception`, `rsp_error`  out  1  shared flags.
- `alu_enable`  out  1  to ALU `enable`.
- `alu_a_in`, `alu_b_in`  out  64  to ALU operands.
- `alu_opcode`  out  4  to ALU opcode.
- `alu_result_out`  in  64  from ALU.
- `alu_exception`, `alu_error`  in  1  from ALU.

## Operation
- FSM states:
  - IDLE: the arbiter picks the first `req_valid` at or after `rr_ptr`. `req_ready[g]` is asserted combinationally in the same cycle. On `req_valid[g] & req_ready[g]`, operands, opcode and owner `g` are registered, `rr_ptr` becomes `(g+1) mod NREQ`, and the FSM goes to EXEC.
  - EXEC: `alu_enable`=1. The cycle counter runs 0..LATENCY-1. On count LATENCY-1, the ALU result and flags are captured into response registers and the FSM goes to RESP.
  - RESP: `rsp_valid[owner]`=1. On `rsp_ready[owner]` the FSM goes to IDLE.
- `alu_a_in`, `alu_b_in` and `alu_opcode` are driven from the operand registers. They hold their values outside EXEC and are never driven directly from `req_*`.
- Requesters keep `req_valid` and their data stable until `req_ready`. A request withdrawn before grant is simply not selected.
- `rsp_ready` from non-owners is ignored. `req_valid` arriving during EXEC or RESP waits; `req_ready` stays 0 outside IDLE.
- Results and flags pass through bit-exact; no arithmetic is performed on them.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_exception`=0, `rsp_error`=0, `alu_enable`=0, `alu_a_in`/`alu_b_in`=0, `alu_opcode`=0. Internal state: `rr_ptr`=0, state=IDLE.
- Accept in cycle T:
  - `alu_enable` is high in cycles T+1..T+LATENCY.
  - `rsp_valid` rises at T+LATENCY+1.
- With `rsp_ready` held high, the minimum issue interval is LATENCY+2 cycles.
- When several requesters are valid at once, only the round-robin winner is granted. A requester never waits more than NREQ-1 grants.
- Reset asserted mid-EXEC or mid-RESP: outputs go to reset values asynchronously, the in-flight operation is dropped, and no response is ever issued for it.

## Configuration
- Macro `SCI_ALU_SCHED_OPCHK_EN`:
  - Defined: opcodes 4'hC..4'hF are reserved. A granted request with a reserved opcode skips EXEC (`alu_enable` stays 0) and goes straight to RESP with `rsp_result`=0, `rsp_error`=1, `rsp_exception`=0. `rsp_valid` then rises at T+1.
  - Undefined: every opcode is forwarded to the ALU unchanged.

## Structure
- Shared package `sci_alu_pkg` holds:
  - `SCI_ALU_DW`=64 and opcode width 4.
  - The `sci_alu_opcode_t` typedef.
  - The first-reserved-opcode constant 4'hC.
  - The scheduler state enum.
- Sub-module `sci_alu_rr_arbiter`: a purely combinational `NREQ`-way round-robin pick from a request vector and pointer, producing a one-hot grant and its index.

## Test plan
- Single request. Requester 1 sends a=64'h3FF8000000000000 (1.5), b=64'h4000000000000000 (2.0), opcode 0. A stub ALU returns a+b. Expected: `rsp_valid[1]` at T+3 with `rsp_result`=64'h400C000000000000 and `alu_enable` high for exactly 2 cycles.
- Contention. All 4 requesters are valid from reset. Expected: grants in order 0,1,2,3,0.
- Response backpressure. `rsp_ready` is held low for 5 cycles. Expected: `rsp_valid` stays high and the result stays stable, and no new `req_ready` is issued until the handshake completes.
- Flag passthrough. The stub drives `alu_error`=1 and `alu_exception`=1. Expected: both appear on `rsp_error` and `rsp_exception` for the owning requester.
- Reset mid-EXEC. Expected: all outputs are 0 immediately, no `rsp_valid` is ever issued for the dropped operation, and the next grant goes to requester 0.
- With `SCI_ALU_SCHED_OPCHK_EN`: opcode 4'hE. Expected: `rsp_error`=1 at T+1, `alu_enable` never asserted.
